wb_mem_slave: RTL and testbench

Pipelined Wishbone B4 slave memory sitting directly downstream of the L1 memory access unit. It accepts the single-word and line-burst requests the unit issues on its Wishbone master port. It returns one in-order `wb_ack_o` (or `wb_err_o`) per accepted request after a fixed latency, and it throttles the master with `wb_stall_o` when too many responses are in flight. It serves as the system-level backing store and as the reference slave for L1 verification.

---
 rtl/wb_mem_slave.sv | 106 ++++++++++
 tb/tb_wb_mem_slave.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_slave.sv
// wb_mem_slave: pipelined Wishbone B4 slave memory with a fixed response
// latency, in-order ack/err responses and outstanding-request throttling.
// Used as the backing store behind the L1 memory access unit.
module wb_mem_slave #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BE_WIDTH        = 4,
    parameter int MEM_WORDS       = 1024,
    parameter int LATENCY         = 3,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic [BE_WIDTH-1:0]   wb_sel_i,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  wb_stall_o
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_WORDS) << 2;

    // Backing store; contents survive reset.
    logic [DATA_WIDTH-1:0] mem_q [0:MEM_WORDS-1];

    // Entry 0 captures the accepted request; entries 1..LATENCY form the
    // delay line, so entry LATENCY is the head seen LATENCY edges later.
    logic [LATENCY:0]      vld_q, vld_d;
    logic [LATENCY:0]      err_q, err_d;
    logic [DATA_WIDTH-1:0] dat_q [0:LATENCY];

    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  accept;
    logic                  in_range;
    logic                  retire;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] acc_dat;

    // Stall is purely registered: a retire this cycle frees a slot next cycle.
    assign wb_stall_o = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign accept     = wb_cyc_i & wb_stb_i & ~wb_stall_o & ~wb_rst_i;
    assign in_range   = ({1'b0, wb_adr_i} < MEM_BYTES);
    assign idx        = wb_adr_i[IDX_W+1:2];

    // Read data is taken from the array before this edge's update; since only
    // one request is accepted per cycle, earlier writes are already visible.
    assign acc_dat    = (!wb_we_i && in_range) ? mem_q[idx] : '0;

    // Responses are suppressed whenever the bus cycle is not active.
    assign wb_ack_o   = vld_q[LATENCY] & ~err_q[LATENCY] & wb_cyc_i;
    assign wb_err_o   = vld_q[LATENCY] &  err_q[LATENCY] & wb_cyc_i;
    assign wb_dat_o   = wb_ack_o ? dat_q[LATENCY] : '0;
    assign retire     = wb_ack_o | wb_err_o;

    // Next-state for pipeline valids, error flags and the outstanding count.
    always_comb begin
        vld_d = {vld_q[LATENCY-1:0], accept};
        err_d = {err_q[LATENCY-1:0], ~in_range};
        cnt_d = cnt_q + CNT_W'(accept) - CNT_W'(retire);
        if (!wb_cyc_i) begin
            vld_d = '0;
            cnt_d = '0;
        end
    end

    // Control state: async reset, abort on cycle drop via next-state logic.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            vld_q <= '0;
            err_q <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    // Response data shift register; qualified by vld_q so no reset needed.
    always_ff @(posedge wb_clk_i) begin
        dat_q[0] <= acc_dat;
        for (int k = 1; k <= LATENCY; k++) begin
            dat_q[k] <= dat_q[k-1];
        end
    end

    // Byte-enabled write of in-range requests at the accept edge.
    always_ff @(posedge wb_clk_i) begin
        if (accept && wb_we_i && in_range) begin
            for (int k = 0; k < BE_WIDTH; k++) begin
                if (wb_sel_i[k]) begin
                    mem_q[idx][k*8 +: 8] <= wb_dat_i[k*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_mem_slave.sv
// tb_wb_mem_slave: scoreboard bench for wb_mem_slave with default parameters.
module tb_wb_mem_slave;

    localparam int LAT = 3;

    logic        clk;
    logic        rst;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [3:0]  sel;
    logic [31:0] dat_r;
    logic        ack;
    logic        err;
    logic        stall;

    wb_mem_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4),
        .MEM_WORDS(1024), .LATENCY(LAT), .MAX_OUTSTANDING(2)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wb_cyc_i  (cyc),
        .wb_stb_i  (stb),
        .wb_we_i   (we),
        .wb_adr_i  (adr),
        .wb_dat_i  (dat_w),
        .wb_sel_i  (sel),
        .wb_dat_o  (dat_r),
        .wb_ack_o  (ack),
        .wb_err_o  (err),
        .wb_stall_o(stall)
    );

    typedef struct {
        logic        err;
        logic [31:0] dat;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mem_m [0:1023];
    int          edge_cnt = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Present a request and hold it until accepted; push the expected response.
    task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output int acc_edge);
        int   n;
        exp_t e;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
        n = 0;
        while (stall && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (stall) begin
            chk("accept_timeout", {63'd0, stall}, 64'd0);
            acc_edge = -1;
            return;
        end
        acc_edge = edge_cnt;
        e.err = (a >= 32'h1000);
        e.dat = 32'h0;
        if (!e.err) begin
            if (w) begin
                for (int k = 0; k < 4; k++)
                    if (s[k]) mem_m[a[11:2]][k*8 +: 8] = d[k*8 +: 8];
            end else begin
                e.dat = mem_m[a[11:2]];
            end
        end
        e.due = edge_cnt + LAT + 1;
        sb_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        stb = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(sb_q.size()), 64'd0);
        @(negedge clk);
    endtask

    // Response monitor: compare every response against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("ack_err_excl", {63'd0, ack & err}, 64'd0);
            if (ack || err) begin
                if (sb_q.size() == 0) begin
                    chk("unexp_resp", {62'd0, ack, err}, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("resp_err", {63'd0, err}, {63'd0, e.err});
                    chk("resp_dat", {32'd0, dat_r}, {32'd0, e.dat});
                    chk("resp_time", 64'(edge_cnt), 64'(e.due));
                end
            end else begin
                chk("dat_idle", {32'd0, dat_r}, 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time 0x%0h expected < 0x%0h", $time, 200000);
        $fatal(1);
    end

    int a0, a1, a2, a3;
    int pre_idx [6] = '{0, 1, 2, 3, 5, 1023};
    logic [31:0] pre_val [6] = '{32'h0A0A_0000, 32'h0A0A_0001, 32'h1122_3344,
                                 32'h0A0A_0003, 32'hDEAD_BEEF, 32'h5A5A_1023};

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = '0; dat_w = '0; sel = '0;

        // Reset state
        @(negedge clk);
        chk("rst_ack", {63'd0, ack}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        chk("rst_dat", {32'd0, dat_r}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Preload through the bus
        for (int i = 0; i < 6; i++) begin
            req(1'b1, 32'(pre_idx[i]) << 2, pre_val[i], 4'hF, a0);
        end
        idle();
        drain();

        // Single read of word 5
        req(1'b0, 32'h14, 32'h0, 4'h0, a0);
        idle();
        chk("t1_stall", {63'd0, stall}, 64'd0);
        drain();

        // Byte-enable write then read back-to-back
        req(1'b1, 32'h08, 32'hAABB_CCDD, 4'b0101, a0);
        req(1'b0, 32'h08, 32'h0, 4'h0, a1);
        idle();
        chk("t2_b2b", 64'(a1 - a0), 64'd1);
        drain();

        // Four back-to-back reads with throttling
        req(1'b0, 32'h00, 32'h0, 4'h0, a0);
        req(1'b0, 32'h04, 32'h0, 4'h0, a1);
        req(1'b0, 32'h08, 32'h0, 4'h0, a2);
        req(1'b0, 32'h0C, 32'h0, 4'h0, a3);
        idle();
        chk("t3_acc1", 64'(a1 - a0), 64'd1);
        chk("t3_acc2", 64'(a2 - a0), 64'd5);
        chk("t3_acc3", 64'(a3 - a0), 64'd6);
        drain();

        // Out of range write and read
        req(1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, a0);
        req(1'b0, 32'h1000, 32'h0, 4'h0, a1);
        idle();
        drain();
        req(1'b0, 32'h000, 32'h0, 4'h0, a0);
        req(1'b0, 32'hFFC, 32'h0, 4'h0, a1);
        idle();
        drain();

        // Cycle abort before any response
        req(1'b0, 32'h00, 32'h0, 4'h0, a0);
        req(1'b0, 32'h04, 32'h0, 4'h0, a1);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        sb_q.delete();
        @(negedge clk);
        cyc = 1'b1;
        chk("t5_stall", {63'd0, stall}, 64'd0);
        repeat (5) @(negedge clk);
        req(1'b0, 32'h0C, 32'h0, 4'h0, a0);
        req(1'b0, 32'h14, 32'h0, 4'h0, a1);
        idle();
        chk("t5_b2b", 64'(a1 - a0), 64'd1);
        drain();

        // Asynchronous reset with a write and a read in flight
        req(1'b1, 32'h1C, 32'h5555_AAAA, 4'hF, a0);
        req(1'b0, 32'h00, 32'h0, 4'h0, a1);
        @(negedge clk);
        stb = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("t6_stall", {63'd0, stall}, 64'd0);
        chk("t6_ack", {63'd0, ack}, 64'd0);
        chk("t6_err", {63'd0, err}, 64'd0);
        chk("t6_dat", {32'd0, dat_r}, 64'd0);
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        req(1'b0, 32'h1C, 32'h0, 4'h0, a0);
        idle();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
